// File: rtl/axi_switch_arbiter_pkg.sv
// Shared types for the AXI switch arbiter: FSM state encoding and the
// fixed width of the switch select bus.
package axi_switch_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2,
    DRAIN  = 2'd3
  } arb_state_t;

  localparam int CS_W = 4;

endpackage

// File: rtl/axi_switch_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first asserted request
// searching upward from rr_last+1, wrapping modulo NUM_SLAVE.
module axi_switch_arbiter_rr_pick
  import axi_switch_arbiter_pkg::*;
#(
  parameter int NUM_SLAVE = 2
) (
  input  logic [NUM_SLAVE-1:0] req,
  input  logic [CS_W-1:0]      rr_last,
  output logic [CS_W-1:0]      winner,
  output logic                 found
);

  localparam int IDX_W = $clog2(NUM_SLAVE);

  int idx;

  // Scan farthest-first so the nearest requester after rr_last overwrites last.
  always_comb begin
    winner = rr_last;
    found  = 1'b0;
    idx    = 0;
    for (int k = NUM_SLAVE; k >= 1; k--) begin
      idx = (int'(rr_last) + k) % NUM_SLAVE;
      if (req[IDX_W'(idx)]) begin
        winner = CS_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_switch_arbiter.sv
// Round-robin owner of the N:1 AXI switch select; rotates CS only when the
// shared port is quiescent and throttles address issue at the outstanding limit.
module axi_switch_arbiter
  import axi_switch_arbiter_pkg::*;
#(
  parameter int NUM_SLAVE       = 2,
  parameter int QUANTUM         = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 s_aclk,
  input  logic                 s_areset,
  input  logic [NUM_SLAVE-1:0] req,
  input  logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic                 m_axi_rvalid,
  input  logic                 m_axi_rready,
  input  logic                 m_axi_rlast,
  input  logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  input  logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic                 m_axi_wlast,
  input  logic                 m_axi_bvalid,
  input  logic                 m_axi_bready,
  output logic [CS_W-1:0]      CS,
  output logic [NUM_SLAVE-1:0] grant,
  output logic                 ar_enable,
  output logic                 aw_enable,
  output logic                 proto_err
);

  localparam int                HOLD_W    = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [HOLD_W-1:0] QUANTUM_H = HOLD_W'(QUANTUM);

  if (NUM_SLAVE < 2 || NUM_SLAVE > 16) begin : g_num_slave_check
    $error("axi_switch_arbiter: NUM_SLAVE must be within 2..16");
  end

  // Returns {underflow, next_count}; inc and dec together cancel out.
  function automatic logic [CNT_W:0] cnt_update(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] nxt;
    logic             uf;
    nxt = cnt;
    uf  = 1'b0;
    if (inc && !dec) begin
      if (cnt != MAX_CNT) nxt = cnt + 1'b1;
    end else if (dec && !inc) begin
      if (cnt == '0) uf  = 1'b1;
      else           nxt = cnt - 1'b1;
    end
    return {uf, nxt};
  endfunction

  function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] h);
    return (h >= QUANTUM_H) ? h : h + 1'b1;
  endfunction

  arb_state_t        state, state_nxt;
  logic [CNT_W-1:0]  rd_cnt, wr_cnt;
  logic [CNT_W:0]    rd_upd, wr_upd;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CS_W-1:0]   rr_last, winner;
  logic              w_mid, found, req_cur, req_other, quiescent, load_winner;
  logic              ar_hs, r_last_hs, aw_hs, w_hs, b_hs;

  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign r_last_hs = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;

  assign rd_upd    = cnt_update(rd_cnt, ar_hs, r_last_hs);
  assign wr_upd    = cnt_update(wr_cnt, aw_hs, b_hs);
  assign quiescent = (rd_cnt == '0) && (wr_cnt == '0) && !w_mid;

  // grant is one-hot of CS whenever a requester owns the port, so it doubles as the owner mask.
  assign req_cur   = |(req & grant);
  assign req_other = |(req & ~grant);

  assign ar_enable = (state == GRANT) && (rd_cnt < MAX_CNT);
  assign aw_enable = (state == GRANT) && (wr_cnt < MAX_CNT);

  axi_switch_arbiter_rr_pick #(.NUM_SLAVE(NUM_SLAVE)) u_rr_pick (
    .req     (req),
    .rr_last (rr_last),
    .winner  (winner),
    .found   (found)
  );

  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      w_mid     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      rd_cnt <= rd_upd[CNT_W-1:0];
      wr_cnt <= wr_upd[CNT_W-1:0];
      if (w_hs) w_mid <= !m_axi_wlast;
      if (rd_upd[CNT_W] || wr_upd[CNT_W]) proto_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_winner = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nxt   = SWITCH;
          load_winner = 1'b1;
        end
      end
      SWITCH: state_nxt = GRANT;
      GRANT: begin
        if (req_other && ((hold_cnt >= QUANTUM_H) || !req_cur)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (quiescent) begin
          if (req_other) begin
            state_nxt   = SWITCH;
            load_winner = 1'b1;
          end else if (req_cur) begin
            state_nxt = GRANT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // CS moves on entry to SWITCH so it is stable a full cycle before enables rise.
  always_ff @(posedge s_aclk or posedge s_areset) begin
    if (s_areset) begin
      state    <= IDLE;
      CS       <= '0;
      grant    <= '0;
      rr_last  <= CS_W'(NUM_SLAVE - 1);
      hold_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_winner) begin
        CS      <= winner;
        grant   <= {{(NUM_SLAVE-1){1'b0}}, 1'b1} << winner;
        rr_last <= winner;
      end else if (state == DRAIN && state_nxt == IDLE) begin
        grant <= '0;
      end
      hold_cnt <= (state == GRANT) ? hold_sat_inc(hold_cnt) : '0;
    end
  end

endmodule

// File: tb/tb_axi_switch_arbiter.sv
// Self-checking bench: random bus traffic against a behavioural arbiter model,
// plus directed underflow, async-reset and round-robin order checks.
module tb_axi_switch_arbiter;

  localparam int N    = 3;
  localparam int Q    = 4;
  localparam int MAXO = 2;

  localparam int P_IDLE = 0;
  localparam int P_SW   = 1;
  localparam int P_GR   = 2;
  localparam int P_DR   = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic arvalid, arready, rvalid, rready, rlast;
  logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]   cs;
  logic [N-1:0] grant;
  logic         ar_en, aw_en, perr;

  axi_switch_arbiter #(
    .NUM_SLAVE       (N),
    .QUANTUM         (Q),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .s_aclk        (clk),
    .s_areset      (rst),
    .req           (req),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .m_axi_rlast   (rlast),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_wlast   (wlast),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .CS            (cs),
    .grant         (grant),
    .ar_enable     (ar_en),
    .aw_enable     (aw_en),
    .proto_err     (perr)
  );

  always #5 clk = ~clk;

  // Reference model state: who owns the port, outstanding totals, error flag.
  int m_phase, m_cs, m_gidx, m_last, m_hold, m_rd, m_wr;
  bit m_wmid, m_err;

  int n_tests, n_fail;
  int order [4];
  int n_ord;
  logic [N-1:0] prev_grant;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rr_winner(input int rq, input int last);
    for (int k = 1; k <= N; k++)
      if (((rq >> ((last + k) % N)) & 1) == 1) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_cs = 0; m_gidx = -1; m_last = N - 1;
    m_hold = 0; m_rd = 0; m_wr = 0; m_wmid = 0; m_err = 0;
  endtask

  task automatic give_port(input int w);
    m_phase = P_SW; m_cs = w; m_gidx = w; m_last = w;
  endtask

  task automatic model_step();
    int rq, mask, d_rd, d_wr;
    bit cur, others, quiet;
    rq     = int'(req);
    mask   = (m_gidx >= 0) ? (1 << m_gidx) : 0;
    cur    = (rq & mask) != 0;
    others = (rq & ~mask) != 0;
    quiet  = (m_rd == 0) && (m_wr == 0) && !m_wmid;
    case (m_phase)
      P_IDLE: if (rq != 0) give_port(rr_winner(rq, m_last));
      P_SW: begin m_phase = P_GR; m_hold = 0; end
      P_GR: begin
        if (others && (m_hold >= Q || !cur)) m_phase = P_DR;
        m_hold = (m_hold < Q) ? m_hold + 1 : Q;
      end
      default: begin
        if (quiet) begin
          if (others)   give_port(rr_winner(rq, m_last));
          else if (cur) begin m_phase = P_GR; m_hold = 0; end
          else          begin m_phase = P_IDLE; m_gidx = -1; end
        end
      end
    endcase
    d_rd = ((arvalid && arready) ? 1 : 0) - ((rvalid && rready && rlast) ? 1 : 0);
    d_wr = ((awvalid && awready) ? 1 : 0) - ((bvalid && bready) ? 1 : 0);
    if (d_rd < 0 && m_rd == 0) m_err = 1;
    else if (m_rd + d_rd <= MAXO) m_rd = m_rd + d_rd;
    if (d_wr < 0 && m_wr == 0) m_err = 1;
    else if (m_wr + d_wr <= MAXO) m_wr = m_wr + d_wr;
    if (wvalid && wready) m_wmid = !wlast;
  endtask

  task automatic check_all();
    chk("cs", 32'(cs), m_cs);
    chk("grant", 32'(grant), (m_gidx < 0) ? 0 : (1 << m_gidx));
    chk("ar_enable", 32'(ar_en), (m_phase == P_GR && m_rd < MAXO) ? 1 : 0);
    chk("aw_enable", 32'(aw_en), (m_phase == P_GR && m_wr < MAXO) ? 1 : 0);
    chk("proto_err", 32'(perr), m_err ? 1 : 0);
  endtask

  task automatic bus_idle();
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0;
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    bvalid = 0; bready = 0;
  endtask

  // Address valids pass through the integrator's AND with the expected enables.
  task automatic drive_random();
    bit exp_ar, exp_aw;
    exp_ar = (m_phase == P_GR) && (m_rd < MAXO);
    exp_aw = (m_phase == P_GR) && (m_wr < MAXO);
    if ($urandom_range(7) == 0) req = N'($urandom_range((1 << N) - 1));
    arvalid = exp_ar && ($urandom_range(1) == 1);
    arready = $urandom_range(9) < 7;
    rvalid  = (m_rd > 0) && ($urandom_range(1) == 1);
    rready  = $urandom_range(3) != 0;
    rlast   = $urandom_range(1) == 1;
    awvalid = exp_aw && ($urandom_range(1) == 1);
    awready = $urandom_range(9) < 7;
    wvalid  = (m_wr > 0 || m_wmid) && ($urandom_range(1) == 1);
    wready  = $urandom_range(3) != 0;
    wlast   = $urandom_range(2) == 0;
    bvalid  = (m_wr > 0) && ($urandom_range(1) == 1);
    bready  = $urandom_range(3) != 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req = '0;
    bus_idle();
    model_reset();
    #1;
    check_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (2500) begin
      drive_random();
      step();
    end

    // Drain reads, then an rlast with nothing outstanding must latch proto_err.
    bus_idle();
    rready = 1; rlast = 1;
    repeat (MAXO + 1) begin
      rvalid = (m_rd > 0);
      step();
    end
    rvalid = 1;
    step();
    chk("proto_err_set", 32'(perr), 1);
    bus_idle();
    repeat (100) begin
      drive_random();
      step();
    end
    chk("proto_err_sticky", 32'(perr), 1);

    req = '1;
    bus_idle();
    for (int c = 0; c < 300 && m_phase != P_GR; c++) step();
    chk("grant_before_reset", (grant != '0) ? 1 : 0, 1);
    rst = 1'b1;
    #1;
    chk("rst_cs", 32'(cs), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_ar_enable", 32'(ar_en), 0);
    chk("rst_aw_enable", 32'(aw_en), 0);
    chk("rst_proto_err", 32'(perr), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    req = 3'b111;
    n_ord = 0;
    prev_grant = '0;
    for (int k = 0; k < 4; k++) order[k] = -1;
    for (int c = 0; c < 200 && n_ord < 4; c++) begin
      step();
      if (grant !== prev_grant && grant !== '0) begin
        order[n_ord] = int'(grant);
        n_ord++;
      end
      prev_grant = grant;
    end
    chk("rr_order_0", order[0], 1);
    chk("rr_order_1", order[1], 2);
    chk("rr_order_2", order[2], 4);
    chk("rr_order_3", order[3], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_switch_arbiter.md
Name: axi_switch_arbiter

Overview:
- Round-robin scheduler that drives the `CS` select of the N-master-to-1-slave AXI switch in the SpMV kernel.
- It grants the shared memory port to one requester at a time and bounds that requester's hold time.
- It changes `CS` only when the port is quiescent: no outstanding read bursts, no write responses pending, no write burst mid-data.
- It also gates new address issue while draining, and at the outstanding-transaction limit.

Parameters:
- NUM_SLAVE, 2, number of requesters sharing the port (2..16).
- QUANTUM, 64, cycles a grant is held before a competing request forces rotation.
- MAX_OUTSTANDING, 8, limit on outstanding read bursts, and separately on outstanding write bursts.
- CNT_W, $clog2(MAX_OUTSTANDING+1), counter width (derived).

Ports:
- s_aclk  in  1  clock
- s_areset  in  1  reset, asynchronous, active-high
- req  in  NUM_SLAVE  per-requester request, driven by (s_axi_arvalid | s_axi_awvalid) of each requester
- m_axi_arvalid, m_axi_arready  in  1 each  muxed AR handshake monitor
- m_axi_rvalid, m_axi_rready, m_axi_rlast  in  1 each  muxed R monitor
- m_axi_awvalid, m_axi_awready  in  1 each  muxed AW monitor
- m_axi_wvalid, m_axi_wready, m_axi_wlast  in  1 each  muxed W monitor
- m_axi_bvalid, m_axi_bready  in  1 each  muxed B monitor
- CS  out  4  select to switch; holds last granted index
- grant  out  NUM_SLAVE  one-hot of the active grant; 0 when no grant
- ar_enable  out  1  integrator ANDs this into m_axi_arvalid and s_axi_arready
- aw_enable  out  1  integrator ANDs this into m_axi_awvalid and s_axi_awready
- proto_err  out  1  sticky; counter underflow detected

Behaviour:
- Reset values: CS=0, grant=0, ar_enable=0, aw_enable=0, proto_err=0, state=IDLE, all counters 0, rr_last=NUM_SLAVE-1, so requester 0 wins first.
- Handshakes are counted every cycle, in every state:
  - rd_cnt: +1 on AR handshake, -1 on R handshake with rlast.
  - wr_cnt: +1 on AW handshake, -1 on B handshake.
  - w_mid: set on a W handshake without wlast; cleared on a W handshake with wlast.
- Simultaneous increment and decrement leaves a counter unchanged.
- A decrement at 0 holds the counter at 0 and sets proto_err; only reset clears proto_err.
- Requesters must not issue W beats before their AW; this is a codebase requirement.
- quiescent = (rd_cnt==0) && (wr_cnt==0) && !w_mid.
- Round-robin: the winner is the first asserted req[i] searching from rr_last+1, modulo NUM_SLAVE.
- State IDLE: enables 0, grant 0. Any req -> SWITCH with the winner.
- State SWITCH (1 cycle):
  - CS and grant take the winner; rr_last=winner; hold_cnt=0; enables 0.
  - This guarantees `CS` is stable for one cycle before any valid passes.
  - Next state is GRANT.
- State GRANT:
  - ar_enable = (rd_cnt<MAX_OUTSTANDING); aw_enable = (wr_cnt<MAX_OUTSTANDING). Both decode from registers only, with no input-to-output combinational path.
  - hold_cnt increments and saturates at QUANTUM.
  - Go to DRAIN if some other req[j] is asserted and either hold_cnt>=QUANTUM or req[CS]==0.
  - If no other requester is asserted, stay in GRANT (parked), even when req[CS]==0.
- State DRAIN:
  - Enables 0; grant unchanged.
  - A handshake accepted in the cycle GRANT->DRAIN is legal and counted.
  - Once quiescent: if another requester is asserted -> SWITCH to its RR winner.
  - Otherwise, if req[CS] -> GRANT with hold_cnt=0; otherwise -> IDLE with grant=0 and CS held.
- Limit: a handshake taking a counter to MAX deasserts the matching enable on the next cycle. The counter can never exceed MAX.
- Reset mid-burst: all state clears immediately (asynchronous). The surrounding kernel is reset in the same domain, so no drain is performed.
- CS width is fixed at 4; NUM_SLAVE>16 is a parameter error, flagged by an elaboration-time check.

Decomposition:
- Shared package/header (pcie_spmv_macros.vh):
  - State encoding constants IDLE/SWITCH/GRANT/DRAIN.
  - CS_W=4.
  - Existing `getvec` macro.
- One natural sub-module: rr_pick. It is a combinational round-robin priority encoder (inputs req, rr_last; outputs winner index, found).
- Counters and FSM stay in the top module.

Test Plan:
- Single requester:
  - Stimulus: req=01, one 4-beat read, then one 4-beat write.
  - Required: CS=0; grant=01 two cycles after req.
  - Required: ar_enable high in GRANT; rd_cnt 1->0 on rlast; wr_cnt 1->0 on B.
  - Required: stays parked in GRANT; no proto_err.
- Rotation after quantum:
  - Stimulus: QUANTUM=8, req=11, requester 0 issues continuous single reads.
  - Required: after 8 GRANT cycles, enables drop; CS=1 only after the last rlast.
  - Required: exactly 1 SWITCH cycle with enables 0; then grant=10.
- Early release:
  - Stimulus: requester 0 drops req with a write burst mid-data (w_mid=1); requester 1 is requesting.
  - Required: DRAIN holds until wlast and B are accepted; then CS=1.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING=2, three back-to-back ARs, rvalid held low.
  - Required: ar_enable=0 after the 2nd handshake; 3rd AR stalls.
  - Required: ar_enable re-asserts the cycle after the first rlast handshake.
- Simultaneous events and error:
  - Stimulus: AW and B handshakes in the same cycle.
  - Required: wr_cnt unchanged.
  - Stimulus: rlast handshake with rd_cnt=0.
  - Required: rd_cnt stays 0 and proto_err=1 until reset.
- Round-robin fairness and async reset:
  - Stimulus: NUM_SLAVE=3, req=111, QUANTUM=4.
  - Required: grant order 0,1,2,0.
  - Stimulus: s_areset asserted mid-GRANT.
  - Required: CS=0, grant=0 and enables=0 immediately, with no clock edge.
